blinker_sysid_checker: RTL and testbench



---
 rtl/blinker_sysid_checker.sv | 152 +++++++++++++++
 tb/tb_blinker_sysid_checker.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blinker_sysid_checker.sv
// blinker_sysid_checker
// Avalon-MM read master that fetches the system ID (word 0) and the build
// timestamp (word 1) from the sysid slave. It compares both words against
// the values the software build expects and reports pass/fail, timeout and
// the captured words.
// Optional interrupt output: define BLINKER_SYSID_CHK_IRQ_EN to add
// irq / irq_clear (sticky irq on a failed or timed-out check).
module blinker_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'd4919,
   parameter logic [31:0] EXPECTED_TS    = 32'd1462918572,
   parameter int          AUTO_START     = 1,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
`ifdef BLINKER_SYSID_CHK_IRQ_EN
   input  logic        irq_clear,
   output logic        irq,
`endif
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout_err,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   // Stall counter is sized to hold TIMEOUT_CYCLES; a disabled timeout
   // still needs a legal one-bit counter.
   localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);
   localparam int          CW        = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int          TO_LAST_I = TO_EN ? (TIMEOUT_CYCLES - 1) : 0;
   localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_ID = 2'd1,
      RD_TS = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic          auto_pend;
   logic          go;
   logic          stall_trip;

   // A check is launched from IDLE (by start or the one-shot auto start)
   // or from DONE by start; start during a read is ignored.
   assign go = ((state == IDLE) && (start || auto_pend)) ||
               ((state == DONE) && start);

   // The current stalled cycle is the TIMEOUT_CYCLES-th stall of this read.
   assign stall_trip = TO_EN && (wait_cnt == TO_LAST);

   // Main sequencer: issues the two reads back to back, captures the data
   // and produces all registered status outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         auto_pend   <= (AUTO_START != 0);
         avm_address <= 1'b0;
         avm_read    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         id_ok       <= 1'b0;
         ts_ok       <= 1'b0;
         timeout_err <= 1'b0;
         id_value    <= '0;
         ts_value    <= '0;
      end else begin
         auto_pend <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (go) begin
                  state       <= RD_ID;
                  wait_cnt    <= '0;
                  avm_address <= 1'b0;
                  avm_read    <= 1'b1;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  id_ok       <= 1'b0;
                  ts_ok       <= 1'b0;
                  timeout_err <= 1'b0;
                  id_value    <= '0;
                  ts_value    <= '0;
               end
            end
            RD_ID, RD_TS: begin
               if (avm_waitrequest) begin
                  if (stall_trip) begin
                     state       <= DONE;
                     wait_cnt    <= '0;
                     avm_read    <= 1'b0;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     timeout_err <= 1'b1;
                     id_ok       <= 1'b0;
                     ts_ok       <= 1'b0;
                  end else begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end else if (state == RD_ID) begin
                  id_value    <= avm_readdata;
                  wait_cnt    <= '0;
                  avm_address <= 1'b1;
                  state       <= RD_TS;
               end else begin
                  ts_value <= avm_readdata;
                  wait_cnt <= '0;
                  avm_read <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  id_ok    <= (id_value == EXPECTED_ID);
                  ts_ok    <= (avm_readdata == EXPECTED_TS);
                  state    <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BLINKER_SYSID_CHK_IRQ_EN
   logic irq_set;

   // Entry into DONE with a bad result: timeout, or either word mismatching.
   assign irq_set = (((state == RD_ID) || (state == RD_TS)) &&
                     avm_waitrequest && stall_trip) ||
                    ((state == RD_TS) && !avm_waitrequest &&
                     ((id_value != EXPECTED_ID) || (avm_readdata != EXPECTED_TS)));

   // Sticky interrupt; a new set beats a simultaneous clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         irq <= 1'b0;
      end else if (irq_set) begin
         irq <= 1'b1;
      end else if (irq_clear || go) begin
         irq <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_blinker_sysid_checker.sv
// Testbench for blinker_sysid_checker: instance 0 uses AUTO_START=1 and
// TIMEOUT_CYCLES=255, instance 1 uses AUTO_START=0 and TIMEOUT_CYCLES=4.
// A behavioural sysid slave answers each read after a configurable number
// of waitrequest cycles.
module tb_blinker_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'd4919;
   localparam logic [31:0] EXP_TS = 32'd1462918572;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic [1:0]        rst_v;
   logic [1:0]        start_v;
   logic [1:0]        irqc_v;
   logic [1:0]        irq_v;
   logic [1:0]        addr_v;
   logic [1:0]        read_v;
   logic [1:0]        wait_v;
   logic [1:0][31:0]  rdata_v;
   logic [1:0]        busy_v;
   logic [1:0]        done_v;
   logic [1:0]        idok_v;
   logic [1:0]        tsok_v;
   logic [1:0]        to_v;
   logic [1:0][31:0]  idv_v;
   logic [1:0][31:0]  tsv_v;

   int n_checks = 0;
   int n_fail   = 0;

   // slave model state
   int          stall_cfg [2][2];
   logic [31:0] mem       [2][2];
   int          seen      [2];
   int          xfers     [2][2];
   logic        prev_act  [2];
   logic        prev_addr [2];

   blinker_sysid_checker #(
      .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
      .AUTO_START(1), .TIMEOUT_CYCLES(255)
   ) dut_a (
      .clock(clock), .reset(rst_v[0]), .start(start_v[0]),
`ifdef BLINKER_SYSID_CHK_IRQ_EN
      .irq_clear(irqc_v[0]), .irq(irq_v[0]),
`endif
      .avm_address(addr_v[0]), .avm_read(read_v[0]),
      .avm_waitrequest(wait_v[0]), .avm_readdata(rdata_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .id_ok(idok_v[0]), .ts_ok(tsok_v[0]),
      .timeout_err(to_v[0]), .id_value(idv_v[0]), .ts_value(tsv_v[0])
   );

   blinker_sysid_checker #(
      .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
      .AUTO_START(0), .TIMEOUT_CYCLES(4)
   ) dut_b (
      .clock(clock), .reset(rst_v[1]), .start(start_v[1]),
`ifdef BLINKER_SYSID_CHK_IRQ_EN
      .irq_clear(irqc_v[1]), .irq(irq_v[1]),
`endif
      .avm_address(addr_v[1]), .avm_read(read_v[1]),
      .avm_waitrequest(wait_v[1]), .avm_readdata(rdata_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .id_ok(idok_v[1]), .ts_ok(tsok_v[1]),
      .timeout_err(to_v[1]), .id_value(idv_v[1]), .ts_value(tsv_v[1])
   );

`ifndef BLINKER_SYSID_CHK_IRQ_EN
   initial irq_v = 2'b00;
`endif

   // Behavioural slave: each new read stalls stall_cfg[i][addr] cycles,
   // then returns mem[i][addr]; completed transfers are counted per address.
   initial begin
      wait_v  = 2'b00;
      rdata_v = '0;
      for (int i = 0; i < 2; i++) begin
         seen[i] = 0; prev_act[i] = 1'b0; prev_addr[i] = 1'b0;
      end
      forever begin
         @(negedge clock);
         for (int i = 0; i < 2; i++) begin
            if (read_v[i]) begin
               if (!prev_act[i] || (addr_v[i] != prev_addr[i])) seen[i] = 0;
               if (seen[i] < stall_cfg[i][addr_v[i]]) begin
                  wait_v[i] = 1'b1;
                  seen[i]++;
               end else begin
                  wait_v[i] = 1'b0;
                  xfers[i][addr_v[i]]++;
               end
               rdata_v[i] = mem[i][addr_v[i]];
            end else begin
               wait_v[i]  = 1'b0;
               rdata_v[i] = 32'hDEAD_BEEF;
            end
            prev_act[i]  = read_v[i];
            prev_addr[i] = addr_v[i];
         end
      end
   end

   typedef struct {
      int          lat;
      bit          to;
      bit          idok;
      bit          tsok;
      logic [31:0] idv;
      logic [31:0] tsv;
      int          nid;
      int          nts;
   } exp_t;

   // Outcome of one check from stall lengths, returned words and timeout limit.
   function automatic exp_t model(input int sid, input int sts,
                                  input logic [31:0] idw, input logic [31:0] tsw,
                                  input int lim);
      exp_t e;
      e.to = 1'b0; e.idok = 1'b0; e.tsok = 1'b0;
      e.idv = '0; e.tsv = '0; e.nid = 0; e.nts = 0; e.lat = 0;
      if (lim != 0 && sid >= lim) begin
         e.to = 1'b1; e.lat = lim;
      end else begin
         e.idv = idw; e.nid = 1;
         if (lim != 0 && sts >= lim) begin
            e.to = 1'b1; e.lat = 1 + sid + lim;
         end else begin
            e.tsv = tsw; e.nts = 1; e.lat = 2 + sid + sts;
            e.idok = (idw == EXP_ID); e.tsok = (tsw == EXP_TS);
         end
      end
      return e;
   endfunction

   // Runs one check on instance i starting at a negedge; extra_k >= 0 pulses
   // start again k edges after the launch edge (must be ignored).
   task automatic run_check(input int i, input int sid, input int sts,
                            input logic [31:0] idw, input logic [31:0] tsw,
                            input int lim, input int extra_k, input string tag);
      exp_t e;
      int   k;
      logic exp_addr;
      e = model(sid, sts, idw, tsw, lim);
      stall_cfg[i][0] = sid; stall_cfg[i][1] = sts;
      mem[i][0] = idw; mem[i][1] = tsw;
      xfers[i][0] = 0; xfers[i][1] = 0;
      start_v[i] = 1'b1;
      @(posedge clock); #1;
      start_v[i] = 1'b0;
      n_checks++;
      if ({busy_v[i], read_v[i], addr_v[i], done_v[i], idok_v[i], tsok_v[i], to_v[i], irq_v[i]} !== 8'b1100_0000) begin
         n_fail++;
         $display("FAIL %s launch: busy/read/addr/done/idok/tsok/to/irq=%b required 11000000", tag,
                  {busy_v[i], read_v[i], addr_v[i], done_v[i], idok_v[i], tsok_v[i], to_v[i], irq_v[i]});
      end
      n_checks++;
      if (idv_v[i] !== 32'd0 || tsv_v[i] !== 32'd0) begin
         n_fail++;
         $display("FAIL %s launch values: id=%h ts=%h required 0/0", tag, idv_v[i], tsv_v[i]);
      end
      k = 0;
      while (!done_v[i] && k < 300) begin
         if (k == extra_k) start_v[i] = 1'b1;
         @(posedge clock); #1;
         start_v[i] = 1'b0;
         k++;
         if (!done_v[i]) begin
            exp_addr = (k <= sid) ? 1'b0 : 1'b1;
            n_checks++;
            if (read_v[i] !== 1'b1 || addr_v[i] !== exp_addr || busy_v[i] !== 1'b1) begin
               n_fail++;
               $display("FAIL %s bus k=%0d: read=%b addr=%b busy=%b required 1/%b/1",
                        tag, k, read_v[i], addr_v[i], busy_v[i], exp_addr);
            end
         end
      end
      n_checks++;
      if (k !== e.lat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d edges required %0d", tag, k, e.lat);
      end
      n_checks++;
      if ({done_v[i], busy_v[i], read_v[i], to_v[i], idok_v[i], tsok_v[i]} !==
          {1'b1, 1'b0, 1'b0, e.to, e.idok, e.tsok}) begin
         n_fail++;
         $display("FAIL %s flags done/busy/read/to/idok/tsok: got %b required %b", tag,
                  {done_v[i], busy_v[i], read_v[i], to_v[i], idok_v[i], tsok_v[i]},
                  {1'b1, 1'b0, 1'b0, e.to, e.idok, e.tsok});
      end
      n_checks++;
      if (idv_v[i] !== e.idv || tsv_v[i] !== e.tsv) begin
         n_fail++;
         $display("FAIL %s values: id=%h ts=%h required %h/%h", tag, idv_v[i], tsv_v[i], e.idv, e.tsv);
      end
      n_checks++;
      if (xfers[i][0] !== e.nid || xfers[i][1] !== e.nts) begin
         n_fail++;
         $display("FAIL %s transfers: addr0=%0d addr1=%0d required %0d/%0d", tag,
                  xfers[i][0], xfers[i][1], e.nid, e.nts);
      end
`ifdef BLINKER_SYSID_CHK_IRQ_EN
      n_checks++;
      if (irq_v[i] !== (e.to || !e.idok || !e.tsok)) begin
         n_fail++;
         $display("FAIL %s irq: got %b required %b", tag, irq_v[i], (e.to || !e.idok || !e.tsok));
      end
      if (e.to || !e.idok || !e.tsok) begin
         @(negedge clock); #2;
         n_checks++;
         if (irq_v[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s irq sticky: got %b required 1", tag, irq_v[i]);
         end
         irqc_v[i] = 1'b1;
         @(posedge clock); #1;
         irqc_v[i] = 1'b0;
         n_checks++;
         if (irq_v[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s irq clear: got %b required 0", tag, irq_v[i]);
         end
      end
`endif
      @(negedge clock);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if ({read_v[i], addr_v[i], busy_v[i], done_v[i], idok_v[i], tsok_v[i], to_v[i], irq_v[i],
              idv_v[i], tsv_v[i]} !== '0) begin
            n_fail++;
            $display("FAIL reset_state inst%0d: read=%b busy=%b done=%b id=%h ts=%h required all 0",
                     i, read_v[i], busy_v[i], done_v[i], idv_v[i], tsv_v[i]);
         end
      end
   endtask

   task automatic test_auto_start();
      xfers[0][0] = 0; xfers[0][1] = 0;
      rst_v = 2'b00;
      @(posedge clock); #1;
      n_checks++;
      if ({busy_v[0], read_v[0], addr_v[0]} !== 3'b110) begin
         n_fail++;
         $display("FAIL auto_first busy/read/addr: got %b required 110", {busy_v[0], read_v[0], addr_v[0]});
      end
      @(posedge clock); #1;
      n_checks++;
      if ({busy_v[0], read_v[0], addr_v[0], done_v[0]} !== 4'b1110 || idv_v[0] !== EXP_ID) begin
         n_fail++;
         $display("FAIL auto_second busy/read/addr/done=%b id=%h required 1110/%h",
                  {busy_v[0], read_v[0], addr_v[0], done_v[0]}, idv_v[0], EXP_ID);
      end
      @(posedge clock); #1;
      n_checks++;
      if ({done_v[0], idok_v[0], tsok_v[0], to_v[0], busy_v[0], read_v[0]} !== 6'b111000) begin
         n_fail++;
         $display("FAIL auto_done done/idok/tsok/to/busy/read: got %b required 111000",
                  {done_v[0], idok_v[0], tsok_v[0], to_v[0], busy_v[0], read_v[0]});
      end
      n_checks++;
      if (idv_v[0] !== 32'h0000_1337 || tsv_v[0] !== EXP_TS || xfers[0][0] !== 1 || xfers[0][1] !== 1) begin
         n_fail++;
         $display("FAIL auto_values id=%h ts=%h xfers=%0d/%0d required 00001337/%h 1/1",
                  idv_v[0], tsv_v[0], xfers[0][0], xfers[0][1], EXP_TS);
      end
      n_checks++;
      if (read_v[1] !== 1'b0 || busy_v[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL no_auto inst1 read=%b busy=%b required 0/0", read_v[1], busy_v[1]);
      end
      @(negedge clock);
   endtask

   task automatic test_no_queue();
      run_check(0, 3, 3, EXP_ID, EXP_TS, 255, 2, "busy_start");
      repeat (3) @(negedge clock);
      n_checks++;
      if ({done_v[0], busy_v[0], read_v[0]} !== 3'b100) begin
         n_fail++;
         $display("FAIL no_queue done/busy/read: got %b required 100", {done_v[0], busy_v[0], read_v[0]});
      end
   endtask

   task automatic test_random(input int i, input int n, input int lim, input int smax);
      int          sid, sts;
      logic [31:0] idw, tsw;
      for (int t = 0; t < n; t++) begin
         sid = $urandom_range(smax, 0);
         sts = $urandom_range(smax, 0);
         idw = ($urandom_range(1, 0) == 1) ? EXP_ID : $urandom;
         tsw = ($urandom_range(1, 0) == 1) ? EXP_TS : $urandom;
         run_check(i, sid, sts, idw, tsw, lim, -1, $sformatf("rand%0d_%0d", i, t));
      end
   endtask

   task automatic test_reset_mid();
      stall_cfg[1][0] = 0; stall_cfg[1][1] = 10;
      mem[1][0] = EXP_ID; mem[1][1] = EXP_TS;
      start_v[1] = 1'b1;
      @(posedge clock); #1;
      start_v[1] = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      rst_v[1] = 1'b1;
      #1;
      n_checks++;
      if ({read_v[1], addr_v[1], busy_v[1], done_v[1], idok_v[1], tsok_v[1], to_v[1], irq_v[1],
           idv_v[1], tsv_v[1]} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: read=%b busy=%b id=%h ts=%h required all 0",
                  read_v[1], busy_v[1], idv_v[1], tsv_v[1]);
      end
      @(negedge clock);
      rst_v[1] = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      n_checks++;
      if (read_v[1] !== 1'b0 || busy_v[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid idle: read=%b busy=%b required 0/0", read_v[1], busy_v[1]);
      end
      @(negedge clock);
   endtask

   initial begin
      rst_v = 2'b11; start_v = 2'b00; irqc_v = 2'b00;
      for (int i = 0; i < 2; i++) begin
         stall_cfg[i][0] = 0; stall_cfg[i][1] = 0;
         mem[i][0] = EXP_ID; mem[i][1] = EXP_TS;
         xfers[i][0] = 0; xfers[i][1] = 0;
      end
      test_reset();
      test_auto_start();
      run_check(0, 3, 3, EXP_ID, EXP_TS, 255, -1, "stall3");
      run_check(0, 0, 0, EXP_ID, 32'd0, 255, -1, "bad_ts");
      run_check(0, 0, 0, 32'h0000_1338, EXP_TS, 255, -1, "bad_id");
      test_no_queue();
      test_random(0, 12, 255, 4);
      run_check(1, 0, 0, EXP_ID, EXP_TS, 4, -1, "b_first");
      run_check(1, 0, 10, EXP_ID, EXP_TS, 4, -1, "to_ts");
      run_check(1, 6, 0, EXP_ID, EXP_TS, 4, -1, "to_id");
      run_check(1, 3, 3, EXP_ID, EXP_TS, 4, -1, "b_edge3");
      test_random(1, 12, 4, 6);
      test_reset_mid();
      run_check(1, 1, 2, EXP_ID, EXP_TS, 4, -1, "after_reset");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
